cordic_seq_ctrl: RTL and testbench

- Sequencing controller for the sequential CORDIC engine.
- On a start request it latches the mode and iteration count, then pulses a load strobe to the x/y/z datapath.
- It then steps the arctangent lookup-table address through 0..N-1, one iteration per clock, and on each cycle supplies the rotation direction decided from the datapath sign feedback.
- It signals completion with a one-cycle done pulse. It sits between the top-level angle/magnitude requester and the CORDIC datapath plus arctangent ROM.

---
 rtl/cordic_seq_ctrl.sv | 72 +++++++
 tb/tb_cordic_seq_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/cordic_seq_ctrl.sv
// cordic_seq_ctrl: sequences load, per-iteration enable/LUT address and rotation direction for a sequential CORDIC datapath.
module cordic_seq_ctrl #(
  parameter int NITER_MAX = 16,
  parameter int ADDR_W = 6,
  parameter int CNT_W = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic abort,
  input  logic rotvec,
  input  logic [CNT_W-1:0] niter,
  input  logic z_sign,
  input  logic y_sign,
  output logic [ADDR_W-1:0] rom_addr,
  output logic load,
  output logic en,
  output logic dir,
  output logic mode,
  output logic busy,
  output logic done
);
  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt, last, n_eff;
  assign n_eff = (niter == '0 || niter > CNT_W'(NITER_MAX)) ? CNT_W'(NITER_MAX) : niter;
  assign rom_addr = ADDR_W'(cnt);
  // Direction steers z towards 0 in rotation mode, y towards 0 in vectoring mode.
  assign dir = en & (mode ? y_sign : ~z_sign);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      last <= '0;
      mode <= 1'b0;
      load <= 1'b0;
      en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      load <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start && !abort) begin
          state <= LOAD;
          mode <= rotvec;
          last <= n_eff - CNT_W'(1);
          cnt <= '0;
          load <= 1'b1;
          busy <= 1'b1;
        end
        LOAD: if (abort) begin
          state <= IDLE;
          busy <= 1'b0;
        end else begin
          state <= ITER;
          en <= 1'b1;
        end
        ITER: if (abort || cnt == last) begin
          state <= abort ? IDLE : DONE;
          done <= !abort;
          en <= 1'b0;
          busy <= 1'b0;
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// tb_cordic_seq_ctrl: randomized self-checking bench comparing each cycle against a timing model of an operation.
module tb_cordic_seq_ctrl;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, rotvec = 1'b0;
  logic z_sign = 1'b0, y_sign = 1'b0;
  logic [4:0] niter = '0;
  logic [5:0] rom_addr;
  logic load, en, dir, mode, busy, done;
  int checks = 0, errors = 0;

  cordic_seq_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .rotvec(rotvec),
    .niter(niter), .z_sign(z_sign), .y_sign(y_sign), .rom_addr(rom_addr),
    .load(load), .en(en), .dir(dir), .mode(mode), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Cycle k after the start edge: k=1 load, k=2..N+1 iterate with addr k-2, k=N+2 done; abort at k<=N+1 idles next cycle.
  task automatic run_op(input logic rv, input logic [4:0] ni, input int ab, input logic hold);
    int n;
    logic [11:0] got, exp;
    logic it;
    n = (ni == 0 || ni > 16) ? 16 : int'(ni);
    start = 1'b1;
    rotvec = rv;
    niter = ni;
    abort = 1'b0;
    step();
    for (int k = 1; k <= n + 2; k++) begin
      start = hold ? 1'b1 : 1'($urandom_range(1));
      rotvec = 1'($urandom);
      niter = 5'($urandom);
      z_sign = 1'($urandom);
      y_sign = 1'($urandom);
      abort = (k == ab);
      #1;
      it = (k >= 2 && k <= n + 1);
      exp = {k == 1, it, k <= n + 1, k == n + 2, it && (rv ? y_sign : !z_sign), rv, it ? 6'(k - 2) : 6'd0};
      got = {load, en, busy, done, dir, mode, rom_addr};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL op rv=%0d ni=%0d k=%0d got(load,en,busy,done,dir,mode,addr)=%b exp=%b", rv, ni, k, got, exp);
      end
      step();
      if (k == ab && k <= n + 1) break;
    end
    abort = 1'b0;
    start = hold;
    z_sign = 1'($urandom);
    y_sign = 1'($urandom);
    #1;
    got = {load, en, busy, done, dir, mode, rom_addr};
    exp = {5'b0, rv, 6'd0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL op_idle rv=%0d ni=%0d ab=%0d got=%b exp=%b", rv, ni, ab, got, exp);
    end
  endtask

  task automatic test_reset();
    logic [11:0] got;
    bit hit = 0;
    step();
    step();
    got = {load, en, busy, done, dir, mode, rom_addr};
    checks++;
    if (got !== 12'b0) begin errors++; $display("FAIL reset_init got=%b exp=0", got); end
    reset = 1'b0;
    start = 1'b1;
    niter = 5'd16;
    rotvec = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (en && rom_addr == 6'd7) begin hit = 1; break; end
      step();
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL reset_reach_addr7 got=%0d exp=7", rom_addr); end
    #2 reset = 1'b1;
    #1;
    got = {load, en, busy, done, dir, mode, rom_addr};
    checks++;
    if (got !== 12'b0) begin errors++; $display("FAIL reset_async got=%b exp=0", got); end
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({done, busy} !== 2'b00) begin errors++; $display("FAIL reset_no_done cyc=%0d got=%b exp=00", i, {done, busy}); end
    end
    run_op(1'b0, 5'd4, 0, 1'b0);
  endtask

  task automatic test_full();
    run_op(1'b0, 5'd16, 0, 1'b0);
  endtask

  task automatic test_clamp();
    run_op(1'b1, 5'd3, 0, 1'b0);
    run_op(1'b0, 5'd0, 0, 1'b0);
    run_op(1'b1, 5'd20, 0, 1'b0);
    run_op(1'b0, 5'd1, 0, 1'b0);
  endtask

  task automatic test_direction();
    run_op(1'b0, 5'd12, 0, 1'b0);
    run_op(1'b1, 5'd12, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_op(1'b1, 5'd5, 0, 1'b1);
    run_op(1'b0, 5'd6, 0, 1'b1);
    start = 1'b0;
    step();
    checks++;
    if ({load, busy} !== 2'b00) begin errors++; $display("FAIL b2b_stop got=%b exp=00", {load, busy}); end
  endtask

  task automatic test_abort();
    run_op(1'b1, 5'd10, 7, 1'b0);
    run_op(1'b0, 5'd8, 1, 1'b0);
    start = 1'b1;
    abort = 1'b1;
    rotvec = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({load, en, busy, done, mode} !== 5'b00000) begin
        errors++;
        $display("FAIL abort_start_idle cyc=%0d got=%b exp=00000", i, {load, en, busy, done, mode});
      end
      step();
    end
    run_op(1'b0, 5'd4, 6, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      logic [4:0] ni;
      int n, ab;
      ni = 5'($urandom);
      n = (ni == 0 || ni > 16) ? 16 : int'(ni);
      ab = $urandom_range(1) == 1 ? int'($urandom_range(1, n + 2)) : 0;
      run_op(1'($urandom), ni, ab, 1'($urandom_range(1)));
      start = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_clamp();
    test_direction();
    test_back_to_back();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
